// File: rtl/sync_pkg.sv
// Shared constants and types for the sync_filter_dff input synchroniser/filter family.
package sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 8;
  localparam int SYNC_FILT_MAX   = 255;
  localparam int GLITCH_CNT_W    = 16;

  typedef logic [GLITCH_CNT_W-1:0] glitch_cnt_t;

  function automatic glitch_cnt_t glitch_cnt_inc_sat(input glitch_cnt_t cnt);
    return (cnt == '1) ? cnt : cnt + glitch_cnt_t'(1);
  endfunction

endpackage

// File: rtl/sync_filter_bit.sv
// One channel: synchroniser chain, consecutive-cycle stability filter and registered edge pulses.
// reject_o exists only when SYNC_FILTER_GLITCH_CNT_EN is defined.
module sync_filter_bit
  import sync_pkg::*;
#(
  parameter int   STAGES      = 3,
  parameter int   FILT_CYCLES = 1,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_o
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  ,
  output logic reject_o
`endif
);

  localparam int CNT_W = $clog2(FILT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CYCLES - 1);

`ifndef SYNTHESIS
  initial begin
    if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX)
      $fatal(1, "sync_filter_bit: STAGES=%0d out of range", STAGES);
    if (FILT_CYCLES < 1 || FILT_CYCLES > SYNC_FILT_MAX)
      $fatal(1, "sync_filter_bit: FILT_CYCLES=%0d out of range", FILT_CYCLES);
  end
`endif

  logic [STAGES-1:0] chain_q, chain_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              level_q, level_d;
  logic              rise_q, rise_d;
  logic              fall_q, fall_d;
  logic              raw;

  assign raw     = chain_q[STAGES-1];
  assign chain_d = {chain_q[STAGES-2:0], sync_i};

  // Any cycle where raw matches the accepted level restarts the count: strictly consecutive.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (raw == level_q) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d   = '0;
      level_d = raw;
      rise_d  = raw;
      fall_d  = ~raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{RST_VAL}};
      cnt_q   <= '0;
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      chain_q <= chain_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sync_o = level_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o  = rise_q | fall_q;

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  assign reject_o = (cnt_q != '0) && (raw == level_q);
`endif

endmodule

// File: rtl/sync_filter_dff.sv
// WIDTH-bit synchroniser with per-bit stability filter and rise/fall/change pulses.
// Define SYNC_FILTER_GLITCH_CNT_EN to add the shared saturating rejected-glitch counter.
module sync_filter_dff
  import sync_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               STAGES      = 3,
  parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
  parameter int               FILT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sync_i,
  output logic [WIDTH-1:0] sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] chg_o
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  ,
  input  logic             glitch_clr_i,
  output glitch_cnt_t      glitch_cnt_o
`endif
);

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic [WIDTH-1:0] reject;
`endif

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sync_filter_bit #(
      .STAGES      (STAGES),
      .FILT_CYCLES (FILT_CYCLES),
      .RST_VAL     (RST_VAL[g])
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .sync_i   (sync_i[g]),
      .sync_o   (sync_o[g]),
      .rise_o   (rise_o[g]),
      .fall_o   (fall_o[g]),
      .chg_o    (chg_o[g])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
      ,
      .reject_o (reject[g])
`endif
    );
  end

`ifdef SYNC_FILTER_GLITCH_CNT_EN
  glitch_cnt_t gcnt_q, gcnt_d;

  // Simultaneous rejects on several bits count as one event; clear wins over increment.
  always_comb begin
    gcnt_d = gcnt_q;
    if (glitch_clr_i) begin
      gcnt_d = '0;
    end else if (|reject) begin
      gcnt_d = glitch_cnt_inc_sat(gcnt_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gcnt_q <= '0;
    end else begin
      gcnt_q <= gcnt_d;
    end
  end

  assign glitch_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_sync_filter_dff.sv
// Scoreboard bench for sync_filter_dff over four parameter sets; honours SYNC_FILTER_GLITCH_CNT_EN.
module tb_sync_filter_dff;

  localparam int NI = 4;
  localparam int         STG  [NI] = '{3, 2, 3, 3};
  localparam int         FLT  [NI] = '{4, 1, 8, 2};
  localparam logic [3:0] RSTV [NI] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] sin [NI];
  logic [3:0] sout[NI];
  logic [3:0] rise[NI];
  logic [3:0] fall[NI];
  logic [3:0] chg [NI];
`ifdef SYNC_FILTER_GLITCH_CNT_EN
  logic        gclr[NI];
  logic [15:0] gcnt[NI];
`endif

  sync_filter_dff #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b1010), .FILT_CYCLES(4)) u_a (
    .clk(clk), .rst(rst), .sync_i(sin[0]), .sync_o(sout[0]),
    .rise_o(rise[0]), .fall_o(fall[0]), .chg_o(chg[0])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    , .glitch_clr_i(gclr[0]), .glitch_cnt_o(gcnt[0])
`endif
  );

  sync_filter_dff #(.WIDTH(4), .STAGES(2), .RST_VAL(4'b0000), .FILT_CYCLES(1)) u_b (
    .clk(clk), .rst(rst), .sync_i(sin[1]), .sync_o(sout[1]),
    .rise_o(rise[1]), .fall_o(fall[1]), .chg_o(chg[1])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    , .glitch_clr_i(gclr[1]), .glitch_cnt_o(gcnt[1])
`endif
  );

  sync_filter_dff #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b0000), .FILT_CYCLES(8)) u_c (
    .clk(clk), .rst(rst), .sync_i(sin[2]), .sync_o(sout[2]),
    .rise_o(rise[2]), .fall_o(fall[2]), .chg_o(chg[2])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    , .glitch_clr_i(gclr[2]), .glitch_cnt_o(gcnt[2])
`endif
  );

  sync_filter_dff #(.WIDTH(4), .STAGES(3), .RST_VAL(4'b0000), .FILT_CYCLES(2)) u_d (
    .clk(clk), .rst(rst), .sync_i(sin[3]), .sync_o(sout[3]),
    .rise_o(rise[3]), .fall_o(fall[3]), .chg_o(chg[3])
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    , .glitch_clr_i(gclr[3]), .glitch_cnt_o(gcnt[3])
`endif
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    int         inst;
    logic [3:0] val;
  } ev_t;
  ev_t evq[$];

  logic [3:0] exp_s[NI];
  logic [3:0] exp_r[NI];
  logic [3:0] exp_f[NI];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk_val($sformatf("sync_o[%0d]", i), 16'(sout[i]), 16'(exp_s[i]));
      chk_val($sformatf("rise_o[%0d]", i), 16'(rise[i]), 16'(exp_r[i]));
      chk_val($sformatf("fall_o[%0d]", i), 16'(fall[i]), 16'(exp_f[i]));
      chk_val($sformatf("chg_o[%0d]", i),  16'(chg[i]),  16'(exp_r[i] | exp_f[i]));
    end
  endtask

  // Retire expected level changes that fall due in this cycle, then compare every output.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      exp_r[i] = '0;
      exp_f[i] = '0;
    end
    for (int k = evq.size() - 1; k >= 0; k--) begin
      if (evq[k].due == cyc) begin
        exp_r[evq[k].inst] = evq[k].val & ~exp_s[evq[k].inst];
        exp_f[evq[k].inst] = ~evq[k].val & exp_s[evq[k].inst];
        exp_s[evq[k].inst] = evq[k].val;
        evq.delete(k);
      end else if (evq[k].due < cyc) begin
        chk_val("stale_event", 16'(evq[k].due), 16'(cyc));
        evq.delete(k);
      end
    end
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) tick();
  endtask

  // Held step: the new value must reach sync_o STAGES+FILT_CYCLES edges later.
  task automatic step(input int i, input logic [3:0] v);
    ev_t e;
    sin[i] = v;
    e.due  = cyc + STG[i] + FLT[i];
    e.inst = i;
    e.val  = v;
    evq.push_back(e);
  endtask

  task automatic poke(input int i, input logic [3:0] v);
    sin[i] = v;
  endtask

  task automatic reset_assert();
    rst = 1'b1;
    #1;
    evq.delete();
    for (int i = 0; i < NI; i++) begin
      exp_s[i] = RSTV[i];
      exp_r[i] = '0;
      exp_f[i] = '0;
    end
    check_all();
  endtask

  task automatic reset_release();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) step(i, sin[i]);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int seen;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      sin[i]   = RSTV[i];
      exp_s[i] = RSTV[i];
      exp_r[i] = '0;
      exp_f[i] = '0;
`ifdef SYNC_FILTER_GLITCH_CNT_EN
      gclr[i] = 1'b0;
`endif
    end

    // Reset with inputs equal to reset value: no pulses during or after release.
    ticks(3);
    reset_release();
    ticks(10);

    // Bit0 step on A: directly measure latency as well as via the scoreboard.
    c0 = cyc;
    step(0, 4'b1011);
    seen = -1;
    for (int j = 0; j < 20 && seen < 0; j++) begin
      tick();
      if (sout[0][0] === 1'b1) seen = cyc - c0;
    end
    chk_val("a_latency", 16'(seen), 16'd7);
    ticks(3);

    // Bring bit1 low, then a 3-cycle high glitch that must be rejected.
    step(0, 4'b1001);
    ticks(12);
    poke(0, 4'b1011);
    ticks(3);
    poke(0, 4'b1001);
    ticks(12);
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    chk_val("a_gcnt_after_glitch", gcnt[0], 16'd1);
    gclr[0] = 1'b1;
    tick();
    gclr[0] = 1'b0;
    chk_val("a_gcnt_after_clr", gcnt[0], 16'd0);
`endif

    // Toggle during count: high 3, low 1, then held high -- count restarts.
    poke(0, 4'b1011);
    ticks(3);
    poke(0, 4'b1001);
    ticks(1);
    step(0, 4'b1011);
    ticks(12);

    // B: FILT_CYCLES=1, STAGES=2, bit2 toggling every 10 cycles.
    for (int k = 0; k < 6; k++) begin
      step(1, (k % 2 == 0) ? 4'b0100 : 4'b0000);
      ticks(10);
    end

    // C: reset while bit3 is mid-count, then acceptance after release.
    poke(2, 4'b1000);
    ticks(8);
    reset_assert();
    ticks(2);
    reset_release();
    ticks(20);

    // D: simultaneous rise on all four bits.
    step(3, 4'hF);
    ticks(10);
`ifdef SYNC_FILTER_GLITCH_CNT_EN
    chk_val("d_gcnt_unchanged", gcnt[3], 16'd0);
`endif
    step(3, 4'h0);
    ticks(10);

    chk_val("events_drained", 16'(evq.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
